// File: rtl/ct_ifu_tage_array_ctrl.sv
// TAGE prediction bank controller: zero sweep after reset/flush,
// lookup vs buffered-update arbitration, one-entry update bypass.
// Ports: forever_cpuclk/cpurst (sync, high); tage_flush;
//   lkp_* lookup handshake + 1-cycle response; upd_* update handshake;
//   init_busy; tage_pred_array_* / tage_pred_bwen drive the SRAM
//   (active-low controls); tage_pre_data_out is the SRAM Q.
module ct_ifu_tage_array_ctrl #(
    parameter int INDEX_W    = 10,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               tage_flush,
    input  logic               lkp_vld,
    output logic               lkp_rdy,
    input  logic [INDEX_W-1:0] lkp_index,
    output logic               lkp_rsp_vld,
    output logic [DATA_W-1:0]  lkp_rsp_data,
    input  logic               upd_vld,
    output logic               upd_rdy,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [DATA_W-1:0]  upd_data,
    input  logic [DATA_W-1:0]  upd_mask,
    output logic               init_busy,
    output logic               tage_pred_array_clk_en,
    output logic               tage_pred_array_cen_b,
    output logic               tage_pred_array_gwen,
    output logic [INDEX_W-1:0] tage_pred_array_index,
    output logic [DATA_W-1:0]  tage_pred_array_din,
    output logic [DATA_W-1:0]  tage_pred_bwen,
    input  logic [DATA_W-1:0]  tage_pre_data_out
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [INDEX_W-1:0] CNT_LAST = '1;

    state_t             state;
    logic [INDEX_W-1:0] cnt;

    logic               buf_vld;
    logic [INDEX_W-1:0] buf_index;
    logic [DATA_W-1:0]  buf_data;
    logic [DATA_W-1:0]  buf_mask;
    logic [2:0]         starve;

    logic               rsp_vld;
    logic [DATA_W-1:0]  byp_data;
    logic [DATA_W-1:0]  byp_mask;

    logic run;
    logic starved;
    logic lkp_go;
    logic upd_go;
    logic upd_acc;
    logic hit;

    assign run       = (state == RUN);
    assign init_busy = (state == INIT);

    // A starved update takes the port even if a lookup is waiting.
    assign starved = buf_vld & (starve == STARVE_LIM);
    assign lkp_rdy = run & ~tage_flush & ~starved;
    assign lkp_go  = lkp_vld & lkp_rdy;
    assign upd_go  = run & ~tage_flush & buf_vld & ~lkp_go;
    assign upd_rdy = ~buf_vld & ~init_busy & ~tage_flush;
    assign upd_acc = upd_vld & upd_rdy;
    assign hit     = buf_vld & (lkp_index == buf_index);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst | tage_flush) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            if (cnt == CNT_LAST) begin
                state <= RUN;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst | tage_flush) begin
            buf_vld <= 1'b0;
            starve  <= '0;
        end else begin
            if (upd_acc) begin
                buf_vld   <= 1'b1;
                buf_index <= upd_index;
                buf_data  <= upd_data;
                buf_mask  <= upd_mask;
            end else if (upd_go) begin
                buf_vld <= 1'b0;
            end
            if (upd_go | ~buf_vld) begin
                starve <= '0;
            end else if (starve != STARVE_LIM) begin
                starve <= starve + 1'b1;
            end
        end
    end

    // Pending update is merged into the response so a lookup never
    // observes stale data while the write is still queued.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rsp_vld  <= 1'b0;
            byp_data <= '0;
            byp_mask <= '0;
        end else begin
            rsp_vld <= lkp_go;
            if (lkp_go) begin
                byp_data <= hit ? buf_data : '0;
                byp_mask <= hit ? buf_mask : '0;
            end
        end
    end

    assign lkp_rsp_vld  = rsp_vld;
    assign lkp_rsp_data = rsp_vld ?
        ((tage_pre_data_out & ~byp_mask) | (byp_data & byp_mask)) : '0;

    always_comb begin
        tage_pred_array_cen_b = 1'b1;
        tage_pred_array_gwen  = 1'b1;
        tage_pred_array_index = '0;
        tage_pred_array_din   = '0;
        tage_pred_bwen        = '1;
        unique case (1'b1)
            init_busy: begin
                tage_pred_array_cen_b = 1'b0;
                tage_pred_array_gwen  = 1'b0;
                tage_pred_array_index = cnt;
                tage_pred_bwen        = '0;
            end
            lkp_go: begin
                tage_pred_array_cen_b = 1'b0;
                tage_pred_array_index = lkp_index;
            end
            upd_go: begin
                tage_pred_array_cen_b = 1'b0;
                tage_pred_array_gwen  = 1'b0;
                tage_pred_array_index = buf_index;
                tage_pred_array_din   = buf_data;
                tage_pred_bwen        = ~buf_mask;
            end
            default: begin
                tage_pred_array_cen_b = 1'b1;
            end
        endcase
    end

    assign tage_pred_array_clk_en = ~tage_pred_array_cen_b;

endmodule

// File: tb/tb_ct_ifu_tage_array_ctrl.sv
// Bench for ct_ifu_tage_array_ctrl with a behavioural SRAM bank.
// Table of update/lookup records plus sweep, bypass, starve, flush, reset.
module tb_ct_ifu_tage_array_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        tage_flush;
    logic        lkp_vld;
    logic        lkp_rdy;
    logic [9:0]  lkp_index;
    logic        lkp_rsp_vld;
    logic [63:0] lkp_rsp_data;
    logic        upd_vld;
    logic        upd_rdy;
    logic [9:0]  upd_index;
    logic [63:0] upd_data;
    logic [63:0] upd_mask;
    logic        init_busy;
    logic        clk_en;
    logic        cen_b;
    logic        gwen;
    logic [9:0]  arr_index;
    logic [63:0] din;
    logic [63:0] bwen;
    logic [63:0] q;

    always #5 clk = ~clk;

    ct_ifu_tage_array_ctrl dut (
        .forever_cpuclk         (clk),
        .cpurst                 (cpurst),
        .tage_flush             (tage_flush),
        .lkp_vld                (lkp_vld),
        .lkp_rdy                (lkp_rdy),
        .lkp_index              (lkp_index),
        .lkp_rsp_vld            (lkp_rsp_vld),
        .lkp_rsp_data           (lkp_rsp_data),
        .upd_vld                (upd_vld),
        .upd_rdy                (upd_rdy),
        .upd_index              (upd_index),
        .upd_data               (upd_data),
        .upd_mask               (upd_mask),
        .init_busy              (init_busy),
        .tage_pred_array_clk_en (clk_en),
        .tage_pred_array_cen_b  (cen_b),
        .tage_pred_array_gwen   (gwen),
        .tage_pred_array_index  (arr_index),
        .tage_pred_array_din    (din),
        .tage_pred_bwen         (bwen),
        .tage_pre_data_out      (q)
    );

    logic [63:0] mem [0:1023];

    always @(posedge clk) begin
        if (!cen_b) begin
            if (!gwen)
                mem[arr_index] <= (mem[arr_index] & bwen) | (din & ~bwen);
            else
                q <= mem[arr_index];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        bit          is_upd;
        logic [9:0]  idx;
        logic [63:0] data;
        logic [63:0] mask;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vec[12];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (lkp_rsp_vld === 1'b1) begin
            sb_t e;
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'(lkp_rsp_vld), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk(e.name, lkp_rsp_data, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [63:0] exp, string name);
        sb_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic do_upd(logic [9:0] idx, logic [63:0] d,
                          logic [63:0] m, string name);
        bit ok;
        ok = 0;
        tick();
        lkp_vld   = 1'b0;
        upd_vld   = 1'b1;
        upd_index = idx;
        upd_data  = d;
        upd_mask  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (upd_rdy) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk({name, "_acc"}, 64'(ok), 64'd1);
        tick();
        upd_vld = 1'b0;
    endtask

    task automatic do_lkp(logic [9:0] idx, logic [63:0] exp, string name);
        bit ok;
        ok = 0;
        tick();
        upd_vld   = 1'b0;
        lkp_vld   = 1'b1;
        lkp_index = idx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lkp_rdy) begin
                push(exp, name);
                ok = 1;
                break;
            end
            tick();
        end
        chk({name, "_acc"}, 64'(ok), 64'd1);
        tick();
        lkp_vld = 1'b0;
    endtask

    // Called at a negedge inside INIT; returns at the first RUN negedge.
    task automatic sweep(string name);
        int busy;
        int bad;
        busy = 0;
        bad  = 0;
        for (int i = 0; i < 1100; i++) begin
            if (init_busy !== 1'b1) break;
            if (arr_index !== busy[9:0] || gwen !== 1'b0 ||
                bwen !== 64'd0 || cen_b !== 1'b0 || din !== 64'd0)
                bad++;
            busy++;
            tick();
            @(negedge clk);
        end
        chk({name, "_len"}, 64'(busy), 64'd1024);
        chk({name, "_seq_bad"}, 64'(bad), 64'd0);
        chk({name, "_run_cen_b"}, 64'(cen_b), 64'd1);
        chk({name, "_run_clk_en"}, 64'(clk_en), 64'd0);
        chk({name, "_run_bwen"}, bwen, '1);
        chk({name, "_run_lkp_rdy"}, 64'(lkp_rdy), 64'd1);
        chk({name, "_run_upd_rdy"}, 64'(upd_rdy), 64'd1);
    endtask

    function automatic vec_t mk(bit u, logic [9:0] i, logic [63:0] d,
                                logic [63:0] m, logic [63:0] e, string n);
        vec_t v;
        v.is_upd = u;
        v.idx    = i;
        v.data   = d;
        v.mask   = m;
        v.exp    = e;
        v.name   = n;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached, test did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d7;
        logic [63:0] m7;
        logic [63:0] e7;

        vec[0]  = mk(1, 10'd5, 64'hFFFF_0000_0000_FFFF,
                     64'h0000_0000_FFFF_FFFF, 64'd0, "upd5a");
        vec[1]  = mk(0, 10'd5, 64'd0, 64'd0,
                     64'h0000_0000_0000_FFFF, "lkp5a");
        vec[2]  = mk(0, 10'd5, 64'd0, 64'd0,
                     64'h0000_0000_0000_FFFF, "lkp5b");
        vec[3]  = mk(1, 10'd5, 64'h1234_5678_9ABC_DEF0,
                     64'hFFFF_FFFF_0000_0000, 64'd0, "upd5b");
        vec[4]  = mk(0, 10'd5, 64'd0, 64'd0,
                     64'h1234_5678_0000_FFFF, "lkp5c");
        vec[5]  = mk(0, 10'd6, 64'd0, 64'd0, 64'd0, "lkp6");
        vec[6]  = mk(1, 10'd1023, '1, '1, 64'd0, "upd1023");
        vec[7]  = mk(0, 10'd1023, 64'd0, 64'd0, '1, "lkp1023a");
        vec[8]  = mk(0, 10'd0, 64'd0, 64'd0, 64'd0, "lkp0a");
        vec[9]  = mk(1, 10'd0, 64'hAAAA_AAAA_AAAA_AAAA,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'd0, "upd0");
        vec[10] = mk(0, 10'd0, 64'd0, 64'd0,
                     64'h0A0A_0A0A_0A0A_0A0A, "lkp0b");
        vec[11] = mk(0, 10'd1023, 64'd0, 64'd0, '1, "lkp1023b");

        cpurst     = 1'b1;
        tage_flush = 1'b0;
        lkp_vld    = 1'b0;
        lkp_index  = '0;
        upd_vld    = 1'b0;
        upd_index  = '0;
        upd_data   = '0;
        upd_mask   = '0;

        tick();
        @(negedge clk);
        chk("rst_init_busy", 64'(init_busy), 64'd1);
        chk("rst_cen_b", 64'(cen_b), 64'd0);
        chk("rst_clk_en", 64'(clk_en), 64'd1);
        chk("rst_gwen", 64'(gwen), 64'd0);
        chk("rst_index", 64'(arr_index), 64'd0);
        chk("rst_din", din, 64'd0);
        chk("rst_bwen", bwen, 64'd0);
        chk("rst_lkp_rdy", 64'(lkp_rdy), 64'd0);
        chk("rst_upd_rdy", 64'(upd_rdy), 64'd0);
        chk("rst_rsp_vld", 64'(lkp_rsp_vld), 64'd0);
        chk("rst_rsp_data", lkp_rsp_data, 64'd0);
        tick();
        cpurst = 1'b0;
        @(negedge clk);
        sweep("sweep0");

        for (int i = 0; i < 12; i++) begin
            if (vec[i].is_upd)
                do_upd(vec[i].idx, vec[i].data, vec[i].mask, vec[i].name);
            else
                do_lkp(vec[i].idx, vec[i].exp, vec[i].name);
        end

        // Same-cycle lookup of an index whose update is still buffered.
        do_upd(10'd7, 64'h5555_5555_5555_5555, '1, "upd7a");
        d7 = 64'hFFFF_FFFF_0000_0000;
        m7 = 64'h00FF_00FF_00FF_00FF;
        e7 = (64'h5555_5555_5555_5555 & ~m7) | (d7 & m7);
        tick();
        upd_vld   = 1'b1;
        upd_index = 10'd7;
        upd_data  = d7;
        upd_mask  = m7;
        @(negedge clk);
        chk("byp_upd_acc", 64'(upd_rdy), 64'd1);
        tick();
        upd_vld   = 1'b0;
        lkp_vld   = 1'b1;
        lkp_index = 10'd7;
        @(negedge clk);
        chk("byp_lkp_rdy", 64'(lkp_rdy), 64'd1);
        chk("byp_read_gwen", 64'(gwen), 64'd1);
        chk("byp_read_index", 64'(arr_index), 64'd7);
        if (lkp_rdy) push(e7, "byp_rsp7");
        tick();
        lkp_vld = 1'b0;
        @(negedge clk);
        chk("byp_wr_gwen", 64'(gwen), 64'd0);
        chk("byp_wr_index", 64'(arr_index), 64'd7);
        chk("byp_wr_din", din, d7);
        chk("byp_wr_bwen", bwen, ~m7);
        do_lkp(10'd7, e7, "lkp7_after");

        // Lookups every cycle while an update waits.
        tick();
        upd_vld   = 1'b1;
        upd_index = 10'd9;
        upd_data  = 64'hDEAD_BEEF_CAFE_F00D;
        upd_mask  = 64'hFFFF_0000_FFFF_0000;
        lkp_vld   = 1'b1;
        lkp_index = 10'd3;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) chk("stv_upd_acc", 64'(upd_rdy), 64'd1);
            chk($sformatf("stv_lkp_rdy_%0d", k), 64'(lkp_rdy),
                64'(k != 5));
            chk($sformatf("stv_gwen_%0d", k), 64'(gwen), 64'(k != 5));
            if (k == 5) chk("stv_wr_index", 64'(arr_index), 64'd9);
            if (lkp_rdy) push(64'd0, "stv_lkp3");
            tick();
            upd_vld = 1'b0;
        end
        lkp_vld = 1'b0;
        do_lkp(10'd9, 64'hDEAD_0000_CAFE_0000, "lkp9");

        // Flush with an update buffered and a lookup presented.
        tick();
        upd_vld   = 1'b1;
        upd_index = 10'd11;
        upd_data  = '1;
        upd_mask  = '1;
        @(negedge clk);
        chk("fl_upd_acc", 64'(upd_rdy), 64'd1);
        tick();
        upd_vld    = 1'b0;
        lkp_vld    = 1'b1;
        lkp_index  = 10'd11;
        tage_flush = 1'b1;
        @(negedge clk);
        chk("fl_lkp_rdy", 64'(lkp_rdy), 64'd0);
        chk("fl_upd_rdy", 64'(upd_rdy), 64'd0);
        chk("fl_cen_b", 64'(cen_b), 64'd1);
        tick();
        tage_flush = 1'b0;
        lkp_vld    = 1'b0;
        @(negedge clk);
        chk("fl_rsp_vld", 64'(lkp_rsp_vld), 64'd0);
        chk("fl_init_busy", 64'(init_busy), 64'd1);
        chk("fl_index0", 64'(arr_index), 64'd0);

        // Second flush in the middle of the sweep.
        for (int i = 0; i < 600; i++) begin
            if (arr_index == 10'd499) break;
            tick();
            @(negedge clk);
        end
        tick();
        tage_flush = 1'b1;
        @(negedge clk);
        chk("fl500_index", 64'(arr_index), 64'd500);
        chk("fl500_busy", 64'(init_busy), 64'd1);
        tick();
        tage_flush = 1'b0;
        @(negedge clk);
        sweep("sweep_fl");
        do_lkp(10'd11, 64'd0, "lkp11_dropped");
        do_lkp(10'd5, 64'd0, "lkp5_zeroed");

        // Reset while an update is buffered and a response is due.
        tick();
        upd_vld   = 1'b1;
        upd_index = 10'd12;
        upd_data  = '1;
        upd_mask  = '1;
        lkp_vld   = 1'b1;
        lkp_index = 10'd13;
        @(negedge clk);
        chk("rs_upd_acc", 64'(upd_rdy), 64'd1);
        if (lkp_rdy) push(64'd0, "rs_lkp13");
        tick();
        upd_vld = 1'b0;
        cpurst  = 1'b1;
        @(negedge clk);
        tick();
        cpurst  = 1'b0;
        lkp_vld = 1'b0;
        @(negedge clk);
        chk("rs_rsp_vld", 64'(lkp_rsp_vld), 64'd0);
        chk("rs_init_busy", 64'(init_busy), 64'd1);
        sweep("sweep_rs");
        do_lkp(10'd12, 64'd0, "lkp12_dropped");

        tick();
        tick();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
